// File: rtl/la_mux3arb.sv
// Round-robin arbiter for three valid/ready sources driving the selects of a la_mux3.
// Optional packet lock keeps the grant until the granted source's last beat is accepted.
module la_mux3arb #(
  parameter PROP = "DEFAULT",
  parameter int unsigned LOCK = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [2:0] req,
  input  logic [2:0] last,
  input  logic       ready,
  output logic [2:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       zvalid,
  output logic [2:0] rdy,
  output logic       busy
);

  localparam int unsigned NREQ = 3;
  localparam int unsigned PW   = 2;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [2:0]    gnt_nxt;
  logic [2:0]    cand;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW-1:0] g_idx;
  logic          accept;
  logic          release_c;

  // PROP only steers target-library mapping; it has no functional effect here.
  if (PROP == "") begin : g_noprop
  end

  // First requester in cand scanning p+1, p+2, p+3 (mod 3).
  function automatic logic [2:0] pick(input logic [2:0] c, input logic [PW-1:0] p);
    logic [2:0]    res;
    logic          found;
    logic [PW-1:0] idx;
    res   = 3'b000;
    found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      idx = PW'((int'(p) + k) % int'(NREQ));
      if (!found && c[idx]) begin
        res   = 3'(1) << idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign g_idx     = gnt[2] ? PW'(2) : (gnt[1] ? PW'(1) : PW'(0));
  assign accept    = (|(gnt & req)) & ready;
  assign release_c = accept & ((LOCK == 0) | last[g_idx]);

  // State, grant, selects and pointer update together so selects never lag the grant.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      gnt   <= 3'b000;
      s0    <= 1'b0;
      s1    <= 1'b0;
      ptr   <= PW'(2);
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      s0    <= gnt_nxt[1];
      s1    <= gnt_nxt[2];
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    cand      = req;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_nxt   = pick(req, ptr);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (release_c) begin
          // Prefer other requesters; re-grant the current one only if it is alone.
          ptr_nxt = g_idx;
          cand    = req & ~gnt;
          if (cand == 3'b000) cand = req;
          gnt_nxt   = pick(cand, g_idx);
          state_nxt = (|gnt_nxt) ? BUSY : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 3'b000;
      end
    endcase
  end

  always_comb begin
    busy   = (state == BUSY);
    zvalid = |(gnt & req);
    rdy    = gnt & {3{ready}};
  end

endmodule

// File: tb/tb_la_mux3arb.sv
// Directed bench for la_mux3arb: expected post-edge outputs are queued when stimulus
// is driven and popped/compared one time unit after the following rising edge.
module tb_la_mux3arb;

  logic       clk;
  logic       nreset;
  logic [2:0] req;
  logic [2:0] last;
  logic       ready;

  logic [2:0] gnt_l, rdy_l, gnt_n, rdy_n;
  logic       s0_l, s1_l, zv_l, busy_l;
  logic       s0_n, s1_n, zv_n, busy_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    bit         nolock;
    logic [9:0] v;
  } exp_t;

  exp_t sbq[$];

  la_mux3arb #(.PROP("DEFAULT"), .LOCK(1)) u_lock (
    .clk(clk), .nreset(nreset), .req(req), .last(last), .ready(ready),
    .gnt(gnt_l), .s0(s0_l), .s1(s1_l), .zvalid(zv_l), .rdy(rdy_l), .busy(busy_l)
  );

  la_mux3arb #(.PROP("DEFAULT"), .LOCK(0)) u_nolock (
    .clk(clk), .nreset(nreset), .req(req), .last(last), .ready(ready),
    .gnt(gnt_n), .s0(s0_n), .s1(s1_n), .zvalid(zv_n), .rdy(rdy_n), .busy(busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic rd);
    req   = r;
    last  = l;
    ready = rd;
  endtask

  // Queue expected {gnt, s1, s0, zvalid, rdy, busy}.
  task automatic expect_out(input string tag, input bit nolock, input logic [2:0] g,
                            input logic [1:0] s, input logic zv, input logic [2:0] r,
                            input logic b);
    exp_t e;
    e.tag    = tag;
    e.nolock = nolock;
    e.v      = {g, s, zv, r, b};
    sbq.push_back(e);
  endtask

  task automatic check_head();
    exp_t       e;
    logic [9:0] obs;
    e   = sbq.pop_front();
    obs = e.nolock ? {gnt_n, s1_n, s0_n, zv_n, rdy_n, busy_n}
                   : {gnt_l, s1_l, s0_l, zv_l, rdy_l, busy_l};
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s: observed gnt,s1s0,zv,rdy,busy=%b expected %b", e.tag, obs, e.v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    while (sbq.size() > 0) check_head();
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    drive(3'b000, 3'b000, 1'b1);
    expect_out("rst_idle", 0, 3'b000, 2'b00, 1'b0, 3'b000, 1'b0);
    tick();
    nreset = 1'b1;
  endtask

  initial begin
    nreset = 1'b0;
    drive(3'b111, 3'b111, 1'b1);
    #1;

    // Reset held with all requests pending.
    for (int i = 0; i < 3; i++) begin
      expect_out("reset_hold", 0, 3'b000, 2'b00, 1'b0, 3'b000, 1'b0);
      tick();
    end
    nreset = 1'b1;
    expect_out("rr0", 0, 3'b001, 2'b00, 1'b1, 3'b001, 1'b1); tick();
    expect_out("rr1", 0, 3'b010, 2'b01, 1'b1, 3'b010, 1'b1); tick();
    expect_out("rr2", 0, 3'b100, 2'b10, 1'b1, 3'b100, 1'b1); tick();
    expect_out("rr3", 0, 3'b001, 2'b00, 1'b1, 3'b001, 1'b1); tick();

    // Packet lock: source 0 sends four beats, source 1 waits.
    do_reset();
    drive(3'b011, 3'b000, 1'b1);
    expect_out("lock_grant", 0, 3'b001, 2'b00, 1'b1, 3'b001, 1'b1); tick();
    expect_out("lock_b1",    0, 3'b001, 2'b00, 1'b1, 3'b001, 1'b1); tick();
    expect_out("lock_b2",    0, 3'b001, 2'b00, 1'b1, 3'b001, 1'b1); tick();
    expect_out("lock_b3",    0, 3'b001, 2'b00, 1'b1, 3'b001, 1'b1); tick();
    drive(3'b011, 3'b001, 1'b1);
    expect_out("lock_handover", 0, 3'b010, 2'b01, 1'b1, 3'b010, 1'b1); tick();

    // Backpressure on source 1, source 0 keeps requesting.
    drive(3'b011, 3'b000, 1'b1);
    expect_out("bp_beat1", 0, 3'b010, 2'b01, 1'b1, 3'b010, 1'b1); tick();
    drive(3'b011, 3'b000, 1'b0);
    expect_out("bp_stall1", 0, 3'b010, 2'b01, 1'b1, 3'b000, 1'b1); tick();
    expect_out("bp_stall2", 0, 3'b010, 2'b01, 1'b1, 3'b000, 1'b1); tick();
    drive(3'b011, 3'b010, 1'b1);
    expect_out("bp_release", 0, 3'b001, 2'b00, 1'b1, 3'b001, 1'b1); tick();

    // No lock: alternate per beat; the locked instance holds source 0.
    do_reset();
    drive(3'b101, 3'b000, 1'b1);
    expect_out("nl_0", 1, 3'b001, 2'b00, 1'b1, 3'b001, 1'b1);
    expect_out("nl_lock0", 0, 3'b001, 2'b00, 1'b1, 3'b001, 1'b1); tick();
    expect_out("nl_1", 1, 3'b100, 2'b10, 1'b1, 3'b100, 1'b1);
    expect_out("nl_lock1", 0, 3'b001, 2'b00, 1'b1, 3'b001, 1'b1); tick();
    expect_out("nl_2", 1, 3'b001, 2'b00, 1'b1, 3'b001, 1'b1); tick();
    expect_out("nl_3", 1, 3'b100, 2'b10, 1'b1, 3'b100, 1'b1); tick();

    // Single requester with last on every beat: continuous grant.
    do_reset();
    drive(3'b100, 3'b100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      expect_out("single", 0, 3'b100, 2'b10, 1'b1, 3'b100, 1'b1);
      tick();
    end

    // Source 2 stalled when it drops req (lock and no-lock both hold).
    drive(3'b000, 3'b000, 1'b1);
    expect_out("hold_noreq", 0, 3'b100, 2'b10, 1'b0, 3'b100, 1'b1);
    expect_out("hold_noreq_nl", 1, 3'b100, 2'b10, 1'b0, 3'b100, 1'b1); tick();

    // Mid-packet asynchronous reset.
    do_reset();
    drive(3'b100, 3'b000, 1'b1);
    expect_out("mr_grant", 0, 3'b100, 2'b10, 1'b1, 3'b100, 1'b1); tick();
    expect_out("mr_beat1", 0, 3'b100, 2'b10, 1'b1, 3'b100, 1'b1); tick();
    #3;
    nreset = 1'b0;
    #1;
    expect_out("mr_async", 0, 3'b000, 2'b00, 1'b0, 3'b000, 1'b0);
    check_head();
    drive(3'b111, 3'b000, 1'b1);
    expect_out("mr_inreset", 0, 3'b000, 2'b00, 1'b0, 3'b000, 1'b0); tick();
    nreset = 1'b1;
    expect_out("mr_restart", 0, 3'b001, 2'b00, 1'b1, 3'b001, 1'b1); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/la_mux3arb.md
Name: la_mux3arb

Overview:
- Round-robin arbitration and select generator for three request streams.
- Drives the s0/s1 selects of a downstream la_mux3 so that one of d0/d1/d2 is steered to a shared output.
- Has packet-lock support, so a multi-beat transfer is never interleaved with another requester's beats.
- Handles the valid/ready handshake between the three sources and the single sink.

Parameters:
PROP, "DEFAULT", implementation property string passed through to the target library; no functional effect.
LOCK, 1, 1 = hold grant until a beat with last is accepted; 0 = re-arbitrate after every accepted beat.

Ports:
clk  input  1  clock; all state updates on rising edge.
nreset  input  1  asynchronous active-low reset.
req  input  3  per-source valid; req[i] = source i has a beat.
last  input  3  per-source end-of-packet flag; qualified by req[i].
ready  input  1  downstream sink accepts the beat this cycle.
gnt  output  3  registered one-hot grant; all zero when idle.
s0  output  1  mux select bit 0; 1 only when gnt[1].
s1  output  1  mux select bit 1; 1 only when gnt[2].
zvalid  output  1  muxed stream valid = |(gnt & req).
rdy  output  3  per-source ready = gnt & {3{ready}}.
busy  output  1  a grant is held.

Behaviour:
- Reset (nreset low, asynchronous): gnt=000, s0=0, s1=0, busy=0, ptr=2. ptr is the index of the last granted source, so input 0 has first priority.
- zvalid and rdy are combinational from registered gnt and the inputs, so they are 0 in reset.
- Select encoding matches the consumer:
  - gnt=001 -> s1s0=00
  - gnt=010 -> s1s0=01
  - gnt=100 -> s1s0=10
  - idle -> 00
  - s1s0=11 is never produced.
- s0 and s1 are registered together with gnt. No glitch between grant and select.
- Arbitration pick: first i with req[i]=1, scanning ptr+1, ptr+2, ptr+3 mod 3.
- State IDLE (busy=0):
  - If |req, load gnt with the pick and go to BUSY next edge.
  - Latency: req rising -> gnt/s valid one cycle later. zvalid the same cycle as gnt.
- State BUSY (busy=1), granted index g:
  - A beat is accepted when req[g] & ready.
  - Release when an accepted beat has (LOCK=0) or (last[g]=1). On release, ptr<=g.
  - Same cycle as release: re-arbitrate over req with ptr=g, but exclude source g unless it is the only requester.
  - If a pick exists, load the new gnt and stay in BUSY: zero-bubble handover.
  - Otherwise gnt<=000 and go to IDLE.
  - No accepted beat: gnt held unchanged.
  - ready low: gnt held.
  - req[g] low: gnt held. With LOCK=1 this stalls until the source returns; with LOCK=0 the grant is still held until a beat is accepted. This is a requirement, not an error.
- Only a single requester: it keeps receiving back-to-back grants, one per packet (LOCK=1) or per beat (LOCK=0), with no idle cycles.
- Simultaneous req on all three from IDLE after reset: grant order 0,1,2,0,...
- last while not granted: ignored. A last on an accepted beat while LOCK=0 has no additional effect.
- Reset mid-packet: grant is dropped immediately (asynchronous). After reset release, arbitration restarts at input 0. The partial packet is not resumed; the source must restart the packet.
- Invariants:
  - gnt is always one-hot or zero.
  - s1&s0 is never 1.
  - At most one rdy bit is high.
  - rdy[i] high implies gnt[i] high.

Test Plan:
- Reset then idle: nreset low 3 cycles with req=111 -> gnt=000, s1s0=00, rdy=000, zvalid=0. Release with req=111, ready=1, last=111, LOCK=1 -> gnt 001,010,100,001 on consecutive cycles, s1s0 00,01,10,00.
- Packet lock: req=011, source0 sends 4 beats with last on beat 4, ready=1 -> gnt=001 for 4 accepted beats, then gnt=010 on the next cycle with no bubble; source1 is never granted mid-packet.
- Backpressure: granted source1, ready toggles 1,0,0,1 with last on the second accepted beat -> gnt=010 and s1s0=01 stay stable through the stalls; rdy[1] follows ready; release happens only after the second accepted beat.
- LOCK=0 interleave: req=101, ready=1, last=000 -> gnt alternates 001,100,001,100 per beat regardless of last.
- Single requester: req=100 only, last=1 each beat -> gnt stays 100 continuously, zvalid=1 every cycle, busy never drops.
- Mid-packet reset: source2 granted, beat 2 of 5; assert nreset asynchronously between edges -> gnt=000 and s1=0 immediately. After release with req=111, the first grant is gnt=001.
